// File: rtl/filter_ker_loader_if.sv
// ----------------------------------------------------------------------------
// filter_ker_loader_if
//   Bundles the kernel-load and image-gating signals of filter_ker_loader.
//   master : upstream side (drives cfg_start/cfg_ker/cfg_val/img_val)
//   slave  : the loader itself (drives cfg_rdy, tap_ker/tap_val, img_rdy,
//            dn_val, busy, done)
//   Signals:
//     cfg_start  request a new kernel load (one-cycle pulse)
//     cfg_ker    incoming weight, tap 0 first
//     cfg_val    cfg_ker valid
//     cfg_rdy    weight accepted when cfg_val & cfg_rdy
//     tap_ker    weight bus shared by all taps
//     tap_val    one-hot load strobe, bit i -> tap i
//     img_val    upstream image sample valid
//     img_rdy    image accepted when img_val & img_rdy
//     dn_val     output of the last tap is valid this cycle
//     busy       loader is draining or loading
//     done       one-cycle pulse on entering RUN
// ----------------------------------------------------------------------------
interface filter_ker_loader_if #(
    parameter int KER_WIDTH = 16,
    parameter int NUM_TAPS  = 4
);
    logic                 cfg_start;
    logic [KER_WIDTH-1:0] cfg_ker;
    logic                 cfg_val;
    logic                 cfg_rdy;
    logic [KER_WIDTH-1:0] tap_ker;
    logic [NUM_TAPS-1:0]  tap_val;
    logic                 img_val;
    logic                 img_rdy;
    logic                 dn_val;
    logic                 busy;
    logic                 done;

    modport master (
        output cfg_start, cfg_ker, cfg_val, img_val,
        input  cfg_rdy, tap_ker, tap_val, img_rdy, dn_val, busy, done
    );

    modport slave (
        input  cfg_start, cfg_ker, cfg_val, img_val,
        output cfg_rdy, tap_ker, tap_val, img_rdy, dn_val, busy, done
    );
endinterface

// File: rtl/filter_ker_loader.sv
// ----------------------------------------------------------------------------
// filter_ker_loader
//   Controller for a chain of NUM_TAPS multiply-add taps. Steers a serial
//   weight stream into the taps one strobe at a time, blocks the image stream
//   until a full kernel is loaded, drains the datapath before a reload and
//   tracks when the end of the chain holds a valid result.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous reset, active-low
//     bus  filter_ker_loader_if.slave (config, tap strobes, image gating)
// ----------------------------------------------------------------------------
module filter_ker_loader #(
    parameter int KER_WIDTH  = 16,
    parameter int NUM_TAPS   = 4,
    parameter int PIPE_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    filter_ker_loader_if.slave     bus
);
    localparam int CW = $clog2(NUM_TAPS);
    localparam int DW = $clog2(PIPE_DEPTH + 1);
    localparam logic [CW-1:0]       LAST_TAP = CW'(NUM_TAPS - 1);
    localparam logic [NUM_TAPS-1:0] TAP0_HOT = NUM_TAPS'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DW-1:0]         drain_q, drain_d;
    logic [KER_WIDTH-1:0]  tap_ker_q, tap_ker_d;
    logic [NUM_TAPS-1:0]   tap_val_q, tap_val_d;
    logic [PIPE_DEPTH-1:0] vp_q, vp_d;
    logic                  cfg_rdy_q, cfg_rdy_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cfg_acc;
    logic                  img_acc;
    logic                  img_rdy;

    // img_rdy is the only combinational output: a reload request closes the
    // gate in the very cycle it is raised so no sample slips in behind it.
    assign img_rdy = (state_q == S_RUN) && !bus.cfg_start;
    assign img_acc = bus.img_val && img_rdy;
    // cfg_rdy_q is high exactly while state_q is LOAD.
    assign cfg_acc = bus.cfg_val && cfg_rdy_q;

    // Next-state, counters, tap strobes and valid pipe.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drain_d   = drain_q;
        tap_ker_d = tap_ker_q;
        tap_val_d = {NUM_TAPS{1'b0}};
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.cfg_start) begin
                    state_d = S_LOAD;
                    cnt_d   = {CW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                // The cfg_start cycle counts as the first drain cycle, so
                // LOAD begins PIPE_DEPTH cycles after cfg_start, right after
                // the last accepted sample has left the chain.
                if (bus.cfg_start) begin
                    state_d = S_DRAIN;
                    drain_d = DW'(PIPE_DEPTH - 1);
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (drain_q <= DW'(1)) begin
                    state_d = S_LOAD;
                    cnt_d   = {CW{1'b0}};
                    drain_d = {DW{1'b0}};
                end else begin
                    drain_d = drain_q - DW'(1);
                end
            end
            S_LOAD: begin
                if (cfg_acc) begin
                    tap_ker_d = bus.cfg_ker;
                    tap_val_d = TAP0_HOT << cnt_q;
                    if (cnt_q == LAST_TAP) begin
                        // cnt stays at the last tap; it is cleared on re-entry.
                        state_d = S_RUN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CW{1'b0}};
                drain_d = {DW{1'b0}};
            end
        endcase
        cfg_rdy_d = (state_d == S_LOAD);
        busy_d    = (state_d == S_DRAIN) || (state_d == S_LOAD);
        vp_d      = (vp_q << 1) | PIPE_DEPTH'(img_acc);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= {CW{1'b0}};
            drain_q   <= {DW{1'b0}};
            tap_ker_q <= {KER_WIDTH{1'b0}};
            tap_val_q <= {NUM_TAPS{1'b0}};
            vp_q      <= {PIPE_DEPTH{1'b0}};
            cfg_rdy_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            drain_q   <= drain_d;
            tap_ker_q <= tap_ker_d;
            tap_val_q <= tap_val_d;
            vp_q      <= vp_d;
            cfg_rdy_q <= cfg_rdy_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.cfg_rdy = cfg_rdy_q;
    assign bus.tap_ker = tap_ker_q;
    assign bus.tap_val = tap_val_q;
    assign bus.img_rdy = img_rdy;
    assign bus.dn_val  = vp_q[PIPE_DEPTH-1];
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
